// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: FSM state encoding and BCD constants.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_LAP   = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    localparam logic [7:0] BCD_WRAP = 8'h99;

    // The time base and the counter only advance in these states.
    function automatic logic is_counting(input state_t s);
        return (s == ST_RUN) || (s == ST_LAP);
    endfunction

endpackage

// File: rtl/btn_cond.sv
// Pushbutton conditioner: 2-FF synchronizer, stable-level debounce and rising-edge detect,
// producing a one-cycle press pulse.
module btn_cond #(
    parameter int DEB_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_press
);

    localparam int              CW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0]   DEB_LAST = CW'(DEB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic          r_prev;
    logic          r_armed;
    logic [1:0]    r_fill;
    logic [CW-1:0] r_cnt;

    // NOTE: asynchronous reset sits in the sensitivity list; every register here is
    // cleared immediately, independent of clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_prev   <= 1'b0;
            r_armed  <= 1'b0;
            r_fill   <= 2'b00;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_prev  <= r_stable;

            // A button held through reset must be seen released before any press counts;
            // r_fill marks when r_sync2 carries a real sample rather than its reset value.
            r_fill <= {r_fill[0], 1'b1};
            if (r_fill[1] && !r_sync2) begin
                r_armed <= 1'b1;
            end

            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == DEB_LAST) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_press = r_stable & ~r_prev & r_armed;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: button conditioning, IDLE/RUN/LAP/PAUSE FSM, 10 Hz prescaler,
// lap capture and registered display mux driving an external two-digit BCD counter.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV   = 1000000,
    parameter int DEB_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_ss,
    input  logic       btn_lc,
    input  logic [7:0] count_in,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic [7:0] disp,
    output logic       running,
    output logic       lap_active,
    output logic       wrap
);

    localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    logic          w_ss_p;
    logic          w_lc_p;
    logic          w_tick;

    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic [7:0]    r_lap;
    logic [7:0]    r_disp;
    logic          r_cnt_en;
    logic          r_cnt_clr;
    logic          r_wrap;
    logic          r_running;
    logic          r_lap_active;

    btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_ss (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (btn_ss),
        .o_press (w_ss_p)
    );

    btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_lc (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (btn_lc),
        .o_press (w_lc_p)
    );

    assign w_tick = is_counting(r_state) && (r_presc == TICK_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_presc      <= '0;
            r_lap        <= 8'h00;
            r_disp       <= 8'h00;
            r_cnt_en     <= 1'b0;
            r_cnt_clr    <= 1'b0;
            r_wrap       <= 1'b0;
            r_running    <= 1'b0;
            r_lap_active <= 1'b0;
        end else begin
            r_cnt_en  <= w_tick;
            r_wrap    <= w_tick && (count_in == BCD_WRAP);
            r_cnt_clr <= 1'b0;
            r_disp    <= (r_state == ST_LAP) ? r_lap : count_in;

            if (!is_counting(r_state) || w_tick) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + PW'(1);
            end

            // NOTE: the transitions below issue later non-blocking assignments to
            // r_presc/r_cnt_clr; the last one in the block wins, overriding the defaults.
            // Start/stop always takes priority over a simultaneous lap/clear press.
            case (r_state)
                ST_IDLE: begin
                    if (w_ss_p) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_ss_p) begin
                        r_state   <= ST_PAUSE;
                        r_presc   <= '0;
                        r_running <= 1'b0;
                    end else if (w_lc_p) begin
                        r_state      <= ST_LAP;
                        r_lap        <= count_in;
                        r_lap_active <= 1'b1;
                    end
                end
                ST_LAP: begin
                    if (w_ss_p) begin
                        r_state      <= ST_PAUSE;
                        r_presc      <= '0;
                        r_running    <= 1'b0;
                        r_lap_active <= 1'b0;
                    end else if (w_lc_p) begin
                        r_state      <= ST_RUN;
                        r_lap_active <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    if (w_ss_p) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end else if (w_lc_p) begin
                        r_state   <= ST_IDLE;
                        r_cnt_clr <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_running    <= 1'b0;
                    r_lap_active <= 1'b0;
                end
            endcase
        end
    end

    assign cnt_en     = r_cnt_en;
    assign cnt_clr    = r_cnt_clr;
    assign disp       = r_disp;
    assign running    = r_running;
    assign lap_active = r_lap_active;
    assign wrap       = r_wrap;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomized self-checking bench for stopwatch_ctrl against an event-level stopwatch model.
module tb_stopwatch_ctrl;

    localparam int TICK_DIV = 4;
    localparam int DEB      = 2;
    localparam int MAXE     = 16384;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       btn_ss   = 1'b0;
    logic       btn_lc   = 1'b0;
    logic [7:0] count_in = 8'h00;
    logic       cnt_en;
    logic       cnt_clr;
    logic [7:0] disp;
    logic       running;
    logic       lap_active;
    logic       wrap;

    stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .DEB_CYCLES(DEB)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_ss     (btn_ss),
        .btn_lc     (btn_lc),
        .count_in   (count_in),
        .cnt_en     (cnt_en),
        .cnt_clr    (cnt_clr),
        .disp       (disp),
        .running    (running),
        .lap_active (lap_active),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    typedef enum int {M_IDLE, M_RUN, M_LAP, M_PAUSE} mode_e;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         edge_n   = 0;
    bit         fix_cnt  = 1'b0;
    // Edge at which an intended press takes effect in the stopwatch
    bit         ss_act [MAXE];
    bit         lc_act [MAXE];

    mode_e      m_mode = M_IDLE;
    int         m_age  = 0;
    logic [7:0] m_lap  = 8'h00;
    logic [7:0] m_disp = 8'h00;
    bit         m_en   = 1'b0;
    bit         m_clr  = 1'b0;
    bit         m_wrap = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] rand_bcd();
        if ($urandom_range(0, 3) == 0) return 8'h99;
        return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
    endfunction

    // Stopwatch behaviour per clock edge; m_age counts edges spent running since entry.
    task automatic model_step(input bit ss, input bit lc, input logic [7:0] cin);
        bit         active;
        bit         tick;
        mode_e      nxt;
        logic [7:0] old_lap;
        active  = (m_mode == M_RUN) || (m_mode == M_LAP);
        tick    = active && (((m_age + 1) % TICK_DIV) == 0);
        nxt     = m_mode;
        old_lap = m_lap;
        m_clr   = 1'b0;
        if (ss) begin
            nxt = (m_mode == M_IDLE || m_mode == M_PAUSE) ? M_RUN : M_PAUSE;
        end else if (lc) begin
            case (m_mode)
                M_RUN:   begin nxt = M_LAP; m_lap = cin; end
                M_LAP:   nxt = M_RUN;
                M_PAUSE: begin nxt = M_IDLE; m_clr = 1'b1; end
                default: nxt = m_mode;
            endcase
        end
        m_disp = (m_mode == M_LAP) ? old_lap : cin;
        m_en   = tick;
        m_wrap = tick && (cin == 8'h99);
        m_age  = (active && (nxt == M_RUN || nxt == M_LAP)) ? m_age + 1 : 0;
        m_mode = nxt;
    endtask

    task automatic cycle();
        edge_n++;
        @(posedge clk);
        model_step((edge_n < MAXE) ? ss_act[edge_n] : 1'b0,
                   (edge_n < MAXE) ? lc_act[edge_n] : 1'b0, count_in);
        @(negedge clk);
        check("running",    running,    (m_mode == M_RUN || m_mode == M_LAP));
        check("lap_active", lap_active, (m_mode == M_LAP));
        check("cnt_en",     cnt_en,     m_en);
        check("cnt_clr",    cnt_clr,    m_clr);
        check("wrap",       wrap,       m_wrap);
        check("disp",       disp,       m_disp);
        if (!fix_cnt) count_in = rand_bcd();
    endtask

    task automatic idle(input int n);
        btn_ss = 1'b0;
        btn_lc = 1'b0;
        repeat (n) cycle();
    endtask

    // A press held for at least DEB samples acts 2+DEB edges after its first sample.
    task automatic press(input bit ss, input bit lc, input int hold);
        int act;
        act = edge_n + 1 + 2 + DEB;
        if (hold >= DEB && act < MAXE) begin
            if (ss) ss_act[act] = 1'b1;
            if (lc) lc_act[act] = 1'b1;
        end
        btn_ss = ss;
        btn_lc = lc;
        repeat (hold) cycle();
        idle(DEB + 2 + $urandom_range(0, 3));
    endtask

    // Asserts reset between clock edges and checks outputs before any edge arrives.
    task automatic apply_reset();
        #2 reset = 1'b1;
        #1;
        check("rst_running",    running,    0);
        check("rst_lap_active", lap_active, 0);
        check("rst_cnt_en",     cnt_en,     0);
        check("rst_cnt_clr",    cnt_clr,    0);
        check("rst_wrap",       wrap,       0);
        check("rst_disp",       disp,       0);
        @(negedge clk);
        @(negedge clk);
        reset  = 1'b0;
        m_mode = M_IDLE;
        m_age  = 0;
        m_lap  = 8'h00;
        m_disp = 8'h00;
        m_en   = 1'b0;
        m_clr  = 1'b0;
        m_wrap = 1'b0;
        for (int i = edge_n + 1; i < edge_n + 32 && i < MAXE; i++) begin
            ss_act[i] = 1'b0;
            lc_act[i] = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        apply_reset();
        idle(10);

        press(1, 0, 3);
        idle(12);
        fix_cnt  = 1'b1;
        count_in = 8'h37;
        press(0, 1, 3);
        fix_cnt  = 1'b0;
        idle(8);
        press(0, 1, 3);
        idle(6);

        press(1, 0, 3);
        press(0, 1, 3);
        idle(4);

        fix_cnt  = 1'b1;
        count_in = 8'h99;
        press(1, 0, 3);
        idle(10);
        fix_cnt  = 1'b0;

        press(1, 1, 3);
        idle(4);
        press(1, 0, 1);
        idle(4);

        repeat (300) begin
            case ($urandom_range(0, 5))
                0, 1:    press(1, 0, DEB + 1 + $urandom_range(0, 2));
                2:       press(0, 1, DEB + 1 + $urandom_range(0, 2));
                3:       press(1, 1, DEB + 1 + $urandom_range(0, 2));
                4:       press($urandom_range(0, 1) == 1, 1'b1, 1);
                default: idle($urandom_range(1, 12));
            endcase
        end

        btn_ss = 1'b1;
        apply_reset();
        repeat (12) cycle();
        idle(6);
        press(1, 0, 3);
        idle(3);
        press(0, 1, 3);
        idle(3);
        apply_reset();
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
